// File: rtl/fetch_unit.sv
// fetch_unit: PC owner issuing in-order imem requests into a small decode queue,
// squashing the queue and in-flight responses on a branch redirect.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        NextPCSrc,
  input  logic [31:0] BranchTarget,
  output logic        IMemReqValid,
  input  logic        IMemReqReady,
  output logic [31:0] IMemReqAddr,
  input  logic        IMemRspValid,
  input  logic [31:0] IMemRspData,
  output logic        InstValid,
  input  logic        InstReady,
  output logic [31:0] Inst,
  output logic [31:0] InstPC
);
  localparam int CW = $clog2(QDEPTH) + 1;
  localparam int PW = $clog2(QDEPTH);
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] out_q, out_d, cnt_q, cnt_d, drop_q, drop_d;
  logic [PW-1:0] pf_wr_q, pf_wr_d, pf_rd_q, pf_rd_d, hd_q, hd_d, tl_q, tl_d;
  logic [31:0] pf_q [QDEPTH];
  logic [31:0] qd_q [QDEPTH];
  logic [31:0] qp_q [QDEPTH];
  logic req_fire, push, pop;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  assign IMemReqValid = !rst && !NextPCSrc && drop_q == '0 &&
                        ({1'b0, out_q} + {1'b0, cnt_q}) < (CW+1)'(QDEPTH);
  assign IMemReqAddr  = fetch_pc_q;
  assign req_fire     = IMemReqValid && IMemReqReady;
  assign InstValid    = cnt_q != '0;
  assign Inst         = InstValid ? qd_q[hd_q] : '0;
  assign InstPC       = InstValid ? qp_q[hd_q] : '0;
  assign pop          = InstValid && InstReady;
  // A response landing in the redirect cycle belongs to the wrong path.
  assign push         = IMemRspValid && drop_q == '0 && !NextPCSrc;
  always_comb begin
    fetch_pc_d = NextPCSrc ? {BranchTarget[31:2], 2'b00} : req_fire ? fetch_pc_q + 32'd4 : fetch_pc_q;
    out_d      = out_q + CW'(req_fire) - CW'(IMemRspValid);
    drop_d     = NextPCSrc ? out_q - CW'(IMemRspValid) : (IMemRspValid && drop_q != '0) ? drop_q - 1'b1 : drop_q;
    cnt_d      = NextPCSrc ? '0 : cnt_q + CW'(push) - CW'(pop);
    hd_d       = NextPCSrc ? '0 : pop ? inc(hd_q) : hd_q;
    tl_d       = NextPCSrc ? '0 : push ? inc(tl_q) : tl_q;
    pf_wr_d    = req_fire ? inc(pf_wr_q) : pf_wr_q;
    pf_rd_d    = IMemRspValid ? inc(pf_rd_q) : pf_rd_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      out_q      <= '0;
      cnt_q      <= '0;
      drop_q     <= '0;
      hd_q       <= '0;
      tl_q       <= '0;
      pf_wr_q    <= '0;
      pf_rd_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      out_q      <= out_d;
      cnt_q      <= cnt_d;
      drop_q     <= drop_d;
      hd_q       <= hd_d;
      tl_q       <= tl_d;
      pf_wr_q    <= pf_wr_d;
      pf_rd_q    <= pf_rd_d;
    end
  end
  always_ff @(posedge clk) begin
    if (req_fire) pf_q[pf_wr_q] <= fetch_pc_q;
    if (push) begin
      qd_q[tl_q] <= IMemRspData;
      qp_q[tl_q] <= pf_q[pf_rd_q];
    end
  end
  assert property (@(posedge clk) disable iff (rst) !(push && !pop && cnt_q == CW'(QDEPTH)));
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed fetch scenarios with a memory model, an expected-instruction
// scoreboard filled on request acceptance and a separate monitor draining it.
module tb_fetch_unit;
  localparam logic [31:0] RPC = 32'h0000_0100;
  logic clk = 0, rst = 1, NextPCSrc = 0, IMemReqReady = 0, IMemRspValid = 0, InstReady = 0;
  logic IMemReqValid, InstValid;
  logic [31:0] BranchTarget = 0, IMemRspData = 0, IMemReqAddr, Inst, InstPC;
  int checks = 0, passes = 0, lat = 1, cyc = 0, last_due = 0;
  logic [31:0] exp_pc = RPC;
  typedef struct {logic [31:0] addr; int due;} mreq_t;
  mreq_t mq[$];
  logic [31:0] sb_pc[$], sb_data[$], got_pc[$];

  fetch_unit #(.RESET_PC(RPC), .QDEPTH(2)) dut (
    .clk(clk), .rst(rst), .NextPCSrc(NextPCSrc), .BranchTarget(BranchTarget),
    .IMemReqValid(IMemReqValid), .IMemReqReady(IMemReqReady), .IMemReqAddr(IMemReqAddr),
    .IMemRspValid(IMemRspValid), .IMemRspData(IMemRspData),
    .InstValid(InstValid), .InstReady(InstReady), .Inst(Inst), .InstPC(InstPC)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // memory model and scoreboard producer
  initial forever begin
    @(negedge clk);
    if (rst) begin
      mq.delete(); sb_pc.delete(); sb_data.delete();
      exp_pc = RPC; last_due = 0; IMemRspValid = 0;
    end else if (mq.size() > 0 && mq[0].due <= cyc) begin
      IMemRspValid = 1;
      IMemRspData = mdata(mq[0].addr);
      void'(mq.pop_front());
    end else begin
      IMemRspValid = 0;
      IMemRspData = 0;
    end
    #3;
    if (!rst) begin
      if (NextPCSrc) begin
        chk("no_req_on_redirect", 32'(IMemReqValid), 0);
        sb_pc.delete(); sb_data.delete();
        exp_pc = {BranchTarget[31:2], 2'b00};
      end else if (IMemReqValid && IMemReqReady) begin
        int due;
        chk("req_addr", IMemReqAddr, exp_pc);
        due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
        last_due = due;
        mq.push_back('{exp_pc, due});
        sb_pc.push_back(exp_pc);
        sb_data.push_back(mdata(exp_pc));
        exp_pc = exp_pc + 32'd4;
      end
    end
  end

  // monitor
  initial forever begin
    @(negedge clk); #2;
    if (!rst && InstValid && InstReady) begin
      got_pc.push_back(InstPC);
      if (sb_pc.size() == 0) begin
        checks++;
        $display("FAIL unexpected_inst: got pc %h with nothing expected", InstPC);
      end else begin
        chk("inst_pc", InstPC, sb_pc.pop_front());
        chk("inst_data", Inst, sb_data.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic wait_pops(input int n);
    int tgt;
    tgt = got_pc.size() + n;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk); #4;
      if (got_pc.size() >= tgt) break;
    end
    chk("pop_timeout", 32'(got_pc.size() >= tgt), 1);
  endtask

  initial begin
    int idx, hit, n0;
    repeat (2) @(negedge clk);
    #4;
    chk("rst_req_valid", 32'(IMemReqValid), 0);
    chk("rst_inst_valid", 32'(InstValid), 0);
    chk("rst_inst", Inst, 0);
    chk("rst_inst_pc", InstPC, 0);
    chk("rst_req_addr", IMemReqAddr, 32'h100);
    @(negedge clk);
    rst = 0; IMemReqReady = 1; InstReady = 1; lat = 1;
    #4;
    chk("first_req_valid", 32'(IMemReqValid), 1);
    chk("first_req_addr", IMemReqAddr, 32'h100);
    idx = got_pc.size();
    wait_pops(6);
    chk("seq_first", got_pc[idx], 32'h100);
    chk("seq_sixth", got_pc[idx+5], 32'h114);
    // decode stall
    @(negedge clk); InstReady = 0;
    repeat (10) @(negedge clk);
    #4;
    chk("stall_req_valid", 32'(IMemReqValid), 0);
    chk("stall_inst_valid", 32'(InstValid), 1);
    @(negedge clk); InstReady = 1;
    wait_pops(4);
    chk("resume_pc", got_pc[idx+6], 32'h118);
    // memory stall
    @(negedge clk); IMemReqReady = 0;
    repeat (5) begin
      @(negedge clk); #4;
      chk("hold_addr", IMemReqAddr, exp_pc);
    end
    chk("drained", 32'(InstValid), 0);
    // two in flight at 3-cycle latency, then redirect
    @(negedge clk); IMemReqReady = 1; lat = 3; NextPCSrc = 1; BranchTarget = 32'h200;
    @(negedge clk); NextPCSrc = 0;
    hit = 0;
    for (int i = 0; i < 10; i++) begin
      #4;
      if (IMemReqValid && IMemReqReady && IMemReqAddr == 32'h204) begin hit = 1; break; end
      @(negedge clk);
    end
    chk("saw_204", 32'(hit), 1);
    @(negedge clk); NextPCSrc = 1; BranchTarget = 32'h403; #4;
    chk("redir_no_req", 32'(IMemReqValid), 0);
    @(negedge clk); NextPCSrc = 0; #4;
    chk("drop1_no_req", 32'(IMemReqValid), 0);
    @(negedge clk); #4;
    chk("drop2_no_req", 32'(IMemReqValid), 0);
    @(negedge clk); #4;
    chk("target_req", 32'(IMemReqValid), 1);
    chk("target_addr", IMemReqAddr, 32'h400);
    idx = got_pc.size();
    wait_pops(1);
    chk("first_after_redir", got_pc[idx], 32'h400);
    // redirect coinciding with a response and a decode pop
    @(negedge clk); lat = 1; NextPCSrc = 1; BranchTarget = 32'h500;
    @(negedge clk); NextPCSrc = 0;
    hit = 0; n0 = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (IMemRspValid && InstValid) begin
        NextPCSrc = 1; BranchTarget = 32'h600; hit = 1; n0 = got_pc.size(); break;
      end
      @(negedge clk);
    end
    chk("overlap_found", 32'(hit), 1);
    #3;
    chk("pop_honoured", 32'(got_pc.size()), 32'(n0 + 1));
    @(negedge clk); NextPCSrc = 0; #4;
    chk("flush_valid", 32'(InstValid), 0);
    idx = got_pc.size();
    wait_pops(1);
    chk("first_after_flush", got_pc[idx], 32'h600);
    // address wrap
    @(negedge clk); NextPCSrc = 1; BranchTarget = 32'hFFFF_FFF9;
    @(negedge clk); NextPCSrc = 0;
    idx = got_pc.size();
    wait_pops(3);
    chk("wrap0", got_pc[idx], 32'hFFFF_FFF8);
    chk("wrap1", got_pc[idx+1], 32'hFFFF_FFFC);
    chk("wrap2", got_pc[idx+2], 32'h0000_0000);
    // asynchronous reset mid-stream
    @(negedge clk); #5; rst = 1; #1;
    chk("arst_req_valid", 32'(IMemReqValid), 0);
    chk("arst_inst_valid", 32'(InstValid), 0);
    chk("arst_inst", Inst, 0);
    chk("arst_inst_pc", InstPC, 0);
    chk("arst_req_addr", IMemReqAddr, 32'h100);
    repeat (2) @(negedge clk);
    rst = 0; #4;
    chk("rerun_req_valid", 32'(IMemReqValid), 1);
    chk("rerun_req_addr", IMemReqAddr, 32'h100);
    idx = got_pc.size();
    wait_pops(2);
    chk("rerun0", got_pc[idx], 32'h100);
    chk("rerun1", got_pc[idx+1], 32'h104);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
